memory_read_scheduler: RTL

// - Shares one read port of the regex-coprocessor instruction memory among N requesters
//   (N-1 engine/station blocks plus the character-class unit) with round-robin fairness.
// - Holds a grant stable while memory stalls, and tags each accepted read with its requester id.
// - After a fixed memory latency, returns read data to the requester that issued that read.
// - Replaces the combinational arbiter plus the "ready implies winner" data broadcast
//   in the mesh topology.

---
 rtl/memory_read_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_read_scheduler.sv
// rtl/memory_read_scheduler.sv - round-robin read-port scheduler with in-flight id tagging
//
// Shares one instruction-memory read port among N requesters. A round-robin
// arbiter picks a requester; a stalled grant is held until memory accepts it.
// Each accepted read is tagged with its requester id and that tag travels
// down a READ_LATENCY-deep pipe so the returning data is flagged for the
// requester that issued it.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active high
//   req_valid_i  [N]      requester i presents an address
//   req_addr_i   [N*AW]   packed addresses, slice i = [i*AW +: AW]
//   req_ready_o  [N]      one-hot: request i accepted this cycle
//   rsp_valid_o  [N]      one-hot: rsp_data_o belongs to requester i
//   rsp_data_o   [MW]     read data, broadcast to all requesters
//   mem_valid_o           address valid towards memory
//   mem_addr_o   [AW]     address towards memory
//   mem_ready_i           memory accepts the address this cycle
//   mem_data_i   [MW]     memory read data, READ_LATENCY cycles after accept
//   busy_o                a grant is held or a read is in flight
module memory_read_scheduler #(
    parameter int N                 = 5,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 20,
    parameter int READ_LATENCY      = 1,
    localparam int ID_WIDTH         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N-1:0]                   req_valid_i,
    input  logic [N*MEMORY_ADDR_WIDTH-1:0] req_addr_i,
    output logic [N-1:0]                   req_ready_o,
    output logic [N-1:0]                   rsp_valid_o,
    output logic [MEMORY_WIDTH-1:0]        rsp_data_o,
    output logic                           mem_valid_o,
    output logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                           mem_ready_i,
    input  logic [MEMORY_WIDTH-1:0]        mem_data_i,
    output logic                           busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   hold_id_q, hold_id_d;

    logic [ID_WIDTH-1:0]   gnt;
    logic                  gnt_found;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  hold_valid;
    logic                  accept;

    logic                  out_v;
    logic [ID_WIDTH-1:0]   out_id;
    logic                  pipe_busy;

    // Round-robin search: first pass covers ids at or above ptr, second
    // pass wraps to the ids below ptr.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_found && (ID_WIDTH'(i) >= ptr_q) && req_valid_i[i]) begin
                gnt       = ID_WIDTH'(i);
                gnt_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_found && (ID_WIDTH'(i) < ptr_q) && req_valid_i[i]) begin
                gnt       = ID_WIDTH'(i);
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        hold_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hold_id_q == ID_WIDTH'(i)) begin
                hold_valid = req_valid_i[i];
            end
        end
    end

    // While holding, the latched id owns the port; no re-arbitration.
    assign sel_id      = (state_q == HOLD) ? hold_id_q : gnt;
    assign mem_valid_o = (state_q == HOLD) ? hold_valid : (|req_valid_i);
    assign accept      = mem_valid_o & mem_ready_i;

    always_comb begin
        mem_addr_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_id == ID_WIDTH'(i)) begin
                mem_addr_o = req_addr_i[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && (sel_id == ID_WIDTH'(i))) begin
                req_ready_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_id_d = hold_id_q;
        if (accept) begin
            ptr_d = (sel_id == ID_WIDTH'(N - 1)) ? '0 : ID_WIDTH'(sel_id + 1'b1);
        end
        case (state_q)
            IDLE: begin
                if (!mem_ready_i && (|req_valid_i)) begin
                    state_d   = HOLD;
                    hold_id_d = gnt;
                end
            end
            HOLD: begin
                // Leave on accept, or if the holder withdrew its request.
                if (accept || !hold_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_id_q <= hold_id_d;
        end
    end

    // Response tag pipe; advances every cycle regardless of mem_ready_i.
    generate
        if (READ_LATENCY == 0) begin : g_nopipe
            assign out_v     = accept;
            assign out_id    = sel_id;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] pv_q;
            logic [ID_WIDTH-1:0]     pid_q [READ_LATENCY];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pv_q <= '0;
                    for (int k = 0; k < READ_LATENCY; k++) begin
                        pid_q[k] <= '0;
                    end
                end else begin
                    pv_q[0]  <= accept;
                    pid_q[0] <= sel_id;
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        pv_q[k]  <= pv_q[k-1];
                        pid_q[k] <= pid_q[k-1];
                    end
                end
            end

            assign out_v     = pv_q[READ_LATENCY-1];
            assign out_id    = pid_q[READ_LATENCY-1];
            assign pipe_busy = |pv_q;
        end
    endgenerate

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < N; i++) begin
            if (out_v && (out_id == ID_WIDTH'(i))) begin
                rsp_valid_o[i] = 1'b1;
            end
        end
    end

    assign rsp_data_o = mem_data_i;
    assign busy_o     = (state_q == HOLD) | pipe_busy;

    // A held requester must keep its request up until it is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == HOLD)) begin
            assert (hold_valid)
            else $error("memory_read_scheduler: held requester dropped req_valid");
        end
    end

endmodule
